// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: writeback source
// selects, sequential PC select value and the memory-wait FSM states.
package hazard_pkg;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_PC4  = 2'd1;
  localparam logic [1:0] WD_LOAD = 2'd2;
  localparam logic [1:0] WD_IMM  = 2'd3;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;

  typedef enum logic {
    StRun  = 1'b0,
    StWait = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_port.sv
// Per-read-port forward select: MEM result beats WB write data, x0 and
// disabled reads never forward, and a MEM load match is flagged as a load-use hit.
module fwd_port
  import hazard_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          re,
  input  logic [AW-1:0] ra,
  input  logic          we_mem,
  input  logic [AW-1:0] wa_mem,
  input  logic [1:0]    wd_sel_mem,
  input  logic [DW-1:0] alu_ans_mem,
  input  logic [DW-1:0] pc_add4_mem,
  input  logic [DW-1:0] imm_mem,
  input  logic          we_wb,
  input  logic [AW-1:0] wa_wb,
  input  logic [DW-1:0] wd_wb,
  output logic [DW-1:0] fd,
  output logic          fe,
  output logic          lu_hit
);

  logic rd_ok;
  logic mem_hit;
  logic wb_hit;

  assign rd_ok   = re && (ra != '0);
  assign mem_hit = rd_ok && we_mem && (wa_mem == ra);
  assign wb_hit  = rd_ok && we_wb && (wa_wb == ra);
  assign lu_hit  = mem_hit && (wd_sel_mem == WD_LOAD);

  always_comb begin
    fe = 1'b0;
    fd = '0;
    if (mem_hit && !lu_hit) begin
      fe = 1'b1;
      unique case (wd_sel_mem)
        WD_ALU:  fd = alu_ans_mem;
        WD_PC4:  fd = pc_add4_mem;
        WD_IMM:  fd = imm_mem;
        default: fd = '0;
      endcase
    end else if (wb_hit) begin
      fe = 1'b1;
      fd = wd_wb;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// 5-stage pipeline hazard controller: MEM/WB forwarding, load-use bubble, branch
// flush, timed data-memory wait and saturating stall/flush counters.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned NRD      = 2,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NRD*AW-1:0] rf_ra_ex,
  input  logic [NRD-1:0]    rf_re_ex,
  input  logic [AW-1:0]     rf_wa_mem,
  input  logic              rf_we_mem,
  input  logic [1:0]        rf_wd_sel_mem,
  input  logic [DW-1:0]     alu_ans_mem,
  input  logic [DW-1:0]     pc_add4_mem,
  input  logic [DW-1:0]     imm_mem,
  input  logic [AW-1:0]     rf_wa_wb,
  input  logic              rf_we_wb,
  input  logic [DW-1:0]     rf_wd_wb,
  input  logic [1:0]        pc_sel_ex,
  input  logic              dmem_req_mem,
  input  logic              dmem_ready,
  output logic [NRD*DW-1:0] rf_rd_fd,
  output logic [NRD-1:0]    rf_rd_fe,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              flush_mem,
  output logic              flush_wb,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              wait_timeout
);

  localparam int unsigned    WCW      = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WaitMax  = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] WaitLast = WCW'(MAX_WAIT - 1);

  logic [NRD*DW-1:0] fd_raw;
  logic [NRD-1:0]    fe_raw;
  logic [NRD-1:0]    lu_hit;
  logic              lu;
  logic              mw;
  logic              br;
  logic              br_flush;

  state_e            state_q;
  logic [WCW-1:0]    wait_cnt_q;
  logic              wait_timeout_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  for (genvar i = 0; i < NRD; i++) begin : g_port
    fwd_port #(
      .DW(DW),
      .AW(AW)
    ) u_fwd_port (
      .re         (rf_re_ex[i]),
      .ra         (rf_ra_ex[i*AW +: AW]),
      .we_mem     (rf_we_mem),
      .wa_mem     (rf_wa_mem),
      .wd_sel_mem (rf_wd_sel_mem),
      .alu_ans_mem(alu_ans_mem),
      .pc_add4_mem(pc_add4_mem),
      .imm_mem    (imm_mem),
      .we_wb      (rf_we_wb),
      .wa_wb      (rf_wa_wb),
      .wd_wb      (rf_wd_wb),
      .fd         (fd_raw[i*DW +: DW]),
      .fe         (fe_raw[i]),
      .lu_hit     (lu_hit[i])
    );
  end

  assign lu       = |lu_hit;
  assign mw       = dmem_req_mem && !dmem_ready;
  assign br       = (pc_sel_ex != PC_SEL_SEQ);
  assign br_flush = br && !mw && !lu;

  // Reset forces bubbles into every stage without waiting for a clock edge.
  always_comb begin
    rf_rd_fd  = rstn ? fd_raw : '0;
    rf_rd_fe  = rstn ? fe_raw : '0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    if (!rstn) begin
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      flush_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (mw) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (lu) begin
      // A pending branch is ignored: its EX operand is not valid until next cycle.
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      flush_mem = 1'b1;
    end else if (br) begin
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
    end
  end

  // The FSM only times the wait; stalls come straight from mw.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StRun;
      wait_cnt_q     <= '0;
      wait_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mw) begin
            state_q    <= StWait;
            wait_cnt_q <= WCW'(1);
          end
        end
        StWait: begin
          if (dmem_ready) begin
            state_q <= StRun;
          end
          if (mw && (wait_cnt_q != WaitMax)) begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
            if (wait_cnt_q == WaitLast) begin
              wait_timeout_q <= 1'b1;
            end
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_if && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (br_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign wait_timeout = wait_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl_mc;
  import hazard_pkg::*;

  localparam int unsigned NRD      = 2;
  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MAX_WAIT = 64;

  logic              clk = 1'b0;
  logic              rstn;
  logic [AW-1:0]     ra0, ra1;
  logic [NRD-1:0]    re;
  logic [AW-1:0]     wa_mem, wa_wb;
  logic              we_mem, we_wb;
  logic [1:0]        sel, pc_sel;
  logic [DW-1:0]     alu, pc4, imm, wd_wb;
  logic              req, rdy;
  logic [NRD*DW-1:0] rd_fd;
  logic [NRD-1:0]    rd_fe;
  logic              s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, f_wb;
  logic [CNT_W-1:0]  scnt, fcnt;
  logic              tmo;

  typedef struct {
    string            name;
    logic [DW-1:0]    fd0;
    logic [DW-1:0]    fd1;
    logic [1:0]       fe;
    logic [3:0]       stall;
    logic [3:0]       flush;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
    logic             to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(
    .NRD(NRD), .DW(DW), .AW(AW), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .rf_ra_ex({ra1, ra0}), .rf_re_ex(re),
    .rf_wa_mem(wa_mem), .rf_we_mem(we_mem), .rf_wd_sel_mem(sel),
    .alu_ans_mem(alu), .pc_add4_mem(pc4), .imm_mem(imm),
    .rf_wa_wb(wa_wb), .rf_we_wb(we_wb), .rf_wd_wb(wd_wb),
    .pc_sel_ex(pc_sel), .dmem_req_mem(req), .dmem_ready(rdy),
    .rf_rd_fd(rd_fd), .rf_rd_fe(rd_fe),
    .stall_if(s_if), .stall_id(s_id), .stall_ex(s_ex), .stall_mem(s_mem),
    .flush_id(f_id), .flush_ex(f_ex), .flush_mem(f_mem), .flush_wb(f_wb),
    .stall_cnt(scnt), .flush_cnt(fcnt), .wait_timeout(tmo)
  );

  // Monitor: one expectation per cycle, compared mid-cycle away from the clock edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (rd_fd[DW-1:0] !== mon_e.fd0 || rd_fd[2*DW-1:DW] !== mon_e.fd1 ||
          rd_fe !== mon_e.fe || {s_if, s_id, s_ex, s_mem} !== mon_e.stall ||
          {f_id, f_ex, f_mem, f_wb} !== mon_e.flush || scnt !== mon_e.scnt ||
          fcnt !== mon_e.fcnt || tmo !== mon_e.to) begin
        n_bad++;
        $display("FAIL %s: got fd0=%h fd1=%h fe=%b stall=%b flush=%b scnt=%0d fcnt=%0d to=%b; want fd0=%h fd1=%h fe=%b stall=%b flush=%b scnt=%0d fcnt=%0d to=%b",
                 mon_e.name, rd_fd[DW-1:0], rd_fd[2*DW-1:DW], rd_fe,
                 {s_if, s_id, s_ex, s_mem}, {f_id, f_ex, f_mem, f_wb}, scnt, fcnt, tmo,
                 mon_e.fd0, mon_e.fd1, mon_e.fe, mon_e.stall, mon_e.flush,
                 mon_e.scnt, mon_e.fcnt, mon_e.to);
      end
    end
  end

  task automatic idle();
    ra0 = '0; ra1 = '0; re = '0;
    we_mem = 1'b0; wa_mem = '0; sel = WD_ALU;
    alu = '0; pc4 = '0; imm = '0;
    we_wb = 1'b0; wa_wb = '0; wd_wb = '0;
    pc_sel = PC_SEL_SEQ; req = 1'b0; rdy = 1'b0;
  endtask

  task automatic expect_v(input string name, input logic [DW-1:0] fd0, input logic [DW-1:0] fd1,
                          input logic [1:0] fe, input logic [3:0] stall, input logic [3:0] flush,
                          input int scnt_e, input int fcnt_e, input logic to);
    exp_t e;
    e.name  = name;
    e.fd0   = fd0;
    e.fd1   = fd1;
    e.fe    = fe;
    e.stall = stall;
    e.flush = flush;
    e.scnt  = CNT_W'(scnt_e);
    e.fcnt  = CNT_W'(fcnt_e);
    e.to    = to;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle, released just after the next edge.
  task automatic pulse_reset(input string name);
    #2;
    rstn = 1'b0;
    expect_v(name, '0, '0, 2'b00, 4'b0000, 4'b1111, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with hazards and a forward match present: outputs must still be reset values.
    idle();
    rstn = 1'b0;
    req = 1'b1;
    re = 2'b01; ra0 = 5'd5; we_mem = 1'b1; wa_mem = 5'd5; alu = 32'h1234;
    step();
    expect_v("reset", '0, '0, 2'b00, 4'b0000, 4'b1111, 0, 0, 1'b0);
    step();
    rstn = 1'b1;

    idle();
    re = 2'b11; ra0 = 5'd5; ra1 = 5'd5;
    we_mem = 1'b1; wa_mem = 5'd5; sel = WD_ALU; alu = 32'h1234;
    we_wb = 1'b1; wa_wb = 5'd5; wd_wb = 32'hDEAD;
    expect_v("alu_fwd_mem_prio", 32'h1234, 32'h1234, 2'b11, 4'b0000, 4'b0000, 0, 0, 1'b0);
    step();

    sel = WD_PC4; pc4 = 32'h100; ra1 = 5'd9; wa_wb = 5'd9;
    expect_v("pc4_fwd_and_wb", 32'h100, 32'hDEAD, 2'b11, 4'b0000, 4'b0000, 0, 0, 1'b0);
    step();

    sel = WD_IMM; imm = 32'hABC; re = 2'b01;
    expect_v("imm_fwd_re_off", 32'hABC, '0, 2'b01, 4'b0000, 4'b0000, 0, 0, 1'b0);
    step();

    idle();
    we_mem = 1'b1; wa_mem = 5'd7; sel = WD_LOAD; re = 2'b10; ra1 = 5'd7; pc_sel = 2'd1;
    expect_v("load_use_with_br", '0, '0, 2'b00, 4'b1110, 4'b0010, 0, 0, 1'b0);
    step();

    idle();
    re = 2'b10; ra1 = 5'd7; we_wb = 1'b1; wa_wb = 5'd7; wd_wb = 32'hBEEF;
    expect_v("load_wb_fwd", '0, 32'hBEEF, 2'b10, 4'b0000, 4'b0000, 1, 0, 1'b0);
    step();

    idle();
    we_mem = 1'b1; wa_mem = 5'd3; sel = WD_LOAD; re = 2'b11; ra0 = 5'd3; ra1 = 5'd3;
    expect_v("lu_both_ports", '0, '0, 2'b00, 4'b1110, 4'b0010, 1, 0, 1'b0);
    step();

    idle();
    we_mem = 1'b1; wa_mem = 5'd0; sel = WD_LOAD; re = 2'b11;
    we_wb = 1'b1; wa_wb = 5'd0; wd_wb = 32'h55;
    expect_v("x0_load", '0, '0, 2'b00, 4'b0000, 4'b0000, 2, 0, 1'b0);
    step();

    idle();
    we_mem = 1'b1; wa_mem = 5'd0; sel = WD_ALU; alu = 32'h77; re = 2'b01;
    expect_v("x0_alu", '0, '0, 2'b00, 4'b0000, 4'b0000, 2, 0, 1'b0);
    step();

    idle();
    pc_sel = 2'd1;
    expect_v("branch", '0, '0, 2'b00, 4'b0000, 4'b1100, 2, 0, 1'b0);
    step();
    pc_sel = PC_SEL_SEQ;
    expect_v("post_branch", '0, '0, 2'b00, 4'b0000, 4'b0000, 2, 1, 1'b0);
    step();
    pc_sel = 2'd3;
    expect_v("branch_sel3", '0, '0, 2'b00, 4'b0000, 4'b1100, 2, 1, 1'b0);
    step();
    pc_sel = PC_SEL_SEQ;
    expect_v("post_branch2", '0, '0, 2'b00, 4'b0000, 4'b0000, 2, 2, 1'b0);
    step();

    pulse_reset("reset_pulse");

    // Memory wait outranks a coincident load-use and branch.
    idle();
    req = 1'b1; we_mem = 1'b1; wa_mem = 5'd7; sel = WD_LOAD; re = 2'b10; ra1 = 5'd7;
    pc_sel = 2'd1;
    expect_v("mw_over_lu_br", '0, '0, 2'b00, 4'b1111, 4'b0001, 0, 0, 1'b0);
    step();
    idle();
    req = 1'b1;
    expect_v("mw_2", '0, '0, 2'b00, 4'b1111, 4'b0001, 1, 0, 1'b0);
    step();
    expect_v("mw_3", '0, '0, 2'b00, 4'b1111, 4'b0001, 2, 0, 1'b0);
    step();
    rdy = 1'b1;
    expect_v("mw_ready", '0, '0, 2'b00, 4'b0000, 4'b0000, 3, 0, 1'b0);
    step();
    expect_v("same_cycle_ready", '0, '0, 2'b00, 4'b0000, 4'b0000, 3, 0, 1'b0);
    step();

    pulse_reset("reset_before_timeout");

    // 64 wait cycles set the timeout; the 4-bit stall counter pins at 15.
    idle();
    for (int i = 0; i < 66; i++) begin
      req = 1'b1;
      rdy = (i == 65);
      expect_v("timeout_run", '0, '0, 2'b00, (i < 65) ? 4'b1111 : 4'b0000,
               (i < 65) ? 4'b0001 : 4'b0000, (i > 15) ? 15 : i, 0, i >= 64);
      step();
    end
    idle();
    expect_v("timeout_sticky", '0, '0, 2'b00, 4'b0000, 4'b0000, 15, 0, 1'b1);
    step();
    req = 1'b1;
    expect_v("mw_again", '0, '0, 2'b00, 4'b1111, 4'b0001, 15, 0, 1'b1);
    step();

    pulse_reset("reset_mid_wait");
    expect_v("after_reset_mw", '0, '0, 2'b00, 4'b1111, 4'b0001, 0, 0, 1'b0);
    step();
    rdy = 1'b1;
    expect_v("after_reset_ready", '0, '0, 2'b00, 4'b0000, 4'b0000, 1, 0, 1'b0);
    step();

    step();
    step();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Parametrised hazard/forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB), generalised to NRD register read ports in EX.
- Provides MEM-over-WB forwarding with x0 suppression, a one-cycle load-use bubble, and branch flush.
- Adds a registered multi-cycle data-memory wait handshake with a timeout flag.
- Adds saturating stall/flush performance counters.
- Sits beside the datapath and drives all stage-register stall/flush controls.

Parameters:
- NRD, 2, number of EX-stage register read ports.
- DW, 32, data width.
- AW, 5, register address width.
- CNT_W, 16, width of the performance counters.
- MAX_WAIT, 64, consecutive memory-wait cycles before wait_timeout is set (must be ≥ 2).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- rf_ra_ex  in  NRD*AW  EX read addresses; port i occupies bits [i*AW +: AW].
- rf_re_ex  in  NRD  EX read enables.
- rf_wa_mem  in  AW  MEM destination register.
- rf_we_mem  in  1  MEM write enable.
- rf_wd_sel_mem  in  2  MEM writeback source select (WD_ALU=0, WD_PC4=1, WD_LOAD=2, WD_IMM=3).
- alu_ans_mem  in  DW  MEM ALU result.
- pc_add4_mem  in  DW  MEM PC+4.
- imm_mem  in  DW  MEM immediate.
- rf_wa_wb  in  AW  WB destination register.
- rf_we_wb  in  1  WB write enable.
- rf_wd_wb  in  DW  WB write data.
- pc_sel_ex  in  2  EX next-PC select; any nonzero value means redirect.
- dmem_req_mem  in  1  MEM stage has an outstanding data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- rf_rd_fd  out  NRD*DW  forwarded data per port.
- rf_rd_fe  out  NRD  forward enable per port.
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the stage register.
- flush_id, flush_ex, flush_mem, flush_wb  out  1 each  load a bubble into the stage register.
- stall_cnt  out  CNT_W  cycles with stall_if=1 (saturating).
- flush_cnt  out  CNT_W  branch-flush cycles (saturating).
- wait_timeout  out  1  sticky memory-timeout flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rstn). All registers reset asynchronously on rstn=0.
- While rstn=0:
  - state=RUN; wait_cnt=0; stall_cnt=0; flush_cnt=0; wait_timeout=0.
  - All stall_*=0; flush_id, flush_ex, flush_mem, flush_wb=1; rf_rd_fe=0; rf_rd_fd=0.
- Forwarding (combinational, 0 latency), per port i, with ra = rf_ra_ex slice i:
  - If rf_re_ex[i]=0 or ra=0: fe=0, fd=0.
  - Else if rf_we_mem, rf_wa_mem==ra and rf_wd_sel_mem≠WD_LOAD: fe=1; fd = alu_ans_mem / pc_add4_mem / imm_mem selected by rf_wd_sel_mem.
  - Else if rf_we_wb and rf_wa_wb==ra: fe=1, fd=rf_wd_wb.
  - Else fe=0, fd=0.
  - MEM strictly beats WB when both match.
- Hazard conditions:
  - lu: some port i has rf_re_ex[i], ra≠0, rf_we_mem, rf_wa_mem==ra and rf_wd_sel_mem==WD_LOAD.
  - mw: dmem_req_mem & ~dmem_ready.
  - br: pc_sel_ex≠0.
- Control outputs (Mealy, priority mw > lu > br):
  - mw: stall_if/id/ex/mem=1; flush_wb=1; all other flushes 0.
  - lu (no mw): stall_if/id/ex=1; flush_mem=1. br is ignored because the EX operand is not valid yet. Next cycle the load is in WB and is forwarded from there.
  - br only: flush_id=1, flush_ex=1.
  - None: all stall and flush outputs 0.
- FSM (state register):
  - RUN→WAIT when mw.
  - WAIT→RUN when dmem_ready.
  - wait_cnt clears on entering WAIT and increments each WAIT cycle that mw holds. Entry cycle counts as 1.
  - When the count reaches MAX_WAIT, wait_timeout is set. It is cleared only by reset.
  - Stall generation does not depend on the FSM state; the FSM only times the wait.
- Counters:
  - stall_cnt += 1 every cycle stall_if=1.
  - flush_cnt += 1 every cycle flush_id=1 due to br.
  - Both saturate at 2^CNT_W−1.
- Boundary conditions:
  - dmem_ready in the same cycle as dmem_req_mem: no stall.
  - Reset asserted mid-WAIT: immediately back to RUN, counters cleared.
  - Load to x0: no lu, no forward.
  - A load hit on multiple ports gives a single bubble.

Decomposition:
- Shared package/header hazard_pkg: WD_ALU, WD_PC4, WD_LOAD, WD_IMM; PC_SEL_SEQ=0; FSM encodings RUN=0, WAIT=1.
- One sub-module fwd_port (combinational, per-port forward select, emits fd/fe plus a per-port lu_hit), instantiated NRD times via generate.

Test Plan:
- ALU forward: MEM writes x5 with alu_ans_mem=0x1234 and WB writes x5=0xDEAD; EX port0 reads x5 → fd0=0x1234, fe0=1 (MEM priority); no stall or flush.
- Load-use: MEM is a load to x7; EX port1 reads x7 → one cycle of stall_if/id/ex=1 and flush_mem=1. Next cycle WB writes x7=0xBEEF → fd1=0xBEEF, fe1=1, no stall.
- Branch: pc_sel_ex=1, no hazard → flush_id=flush_ex=1 for one cycle; flush_cnt=1. Branch coincident with load-use → no flush that cycle.
- Memory wait: dmem_req_mem=1, dmem_ready low for 3 cycles → stall_if..mem=1 and flush_wb=1 for 3 cycles, stall_cnt=3, back to RUN on ready.
- Timeout: dmem_ready held low for MAX_WAIT=64 cycles → wait_timeout=1 and stays 1 after ready; drop rstn mid-wait → outputs return to reset values asynchronously.
- x0 and saturation: EX reads x0 while MEM writes x0 → fe=0. With CNT_W=4 and 20 stall cycles → stall_cnt=15.
